// File: rtl/parity_frame_tx.sv
// Serial transmitter for 9-bit even-parity words {data[7:0], parity}.
// Sends 11-bit frames (start, data LSB first, parity, stop) and flags bad parity on accept.
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int BAUD_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_valid,
  input  logic [8:0] din,
  output logic       din_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t            state;
  state_t            next_state;
  logic              buf_full;
  logic [8:0]        buf_word;
  logic [7:0]        shift_reg;
  logic              par_bit;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic              bit_end;
  logic              accept;
  logic              load;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign din_ready = rst_n && !buf_full;
  assign accept    = din_valid && din_ready;
  // Buffer drains into the shifter from IDLE, or straight out of the last stop cycle.
  assign load      = buf_full && ((state == IDLE) || ((state == STOP) && bit_end));
  assign busy      = (state != IDLE) || buf_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tx_out     = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (buf_full) next_state = START;
      end
      START: begin
        tx_out = 1'b0;
        if (bit_end) next_state = DATA;
      end
      DATA: begin
        tx_out = shift_reg[0];
        if (bit_end && (bit_cnt == 3'd7)) next_state = PARITY;
      end
      PARITY: begin
        tx_out = par_bit;
        if (bit_end) next_state = STOP;
      end
      STOP: begin
        frame_done = bit_end;
        if (bit_end) next_state = buf_full ? START : IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full   <= 1'b0;
      buf_word   <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= accept && (din[0] != ^din[8:1]);
      if (accept) begin
        buf_full <= 1'b1;
        buf_word <= din;
      end else if (load) begin
        buf_full <= 1'b0;
      end
      if (load) begin
        shift_reg <= buf_word[8:1];
        par_bit   <= buf_word[0];
        baud_cnt  <= '0;
        bit_cnt   <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          baud_cnt <= '0;
          if (state == DATA) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + BAUD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx: accepted words become expected line frames
// in a queue; a per-cycle monitor compares the line and status outputs against them.
module tb_parity_frame_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 11 * CPB;

  typedef struct {
    int          s;
    logic [10:0] bits;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic       din_valid;
  logic [8:0] din;
  logic       din_ready;
  logic       tx_out;
  logic       busy;
  logic       parity_err;
  logic       frame_done;

  int     checks;
  int     errors;
  int     n;
  int     last_start;
  int     last_end;
  bit     armed;
  logic   exp_perr;
  frame_t q[$];

  parity_frame_tx #(.CLKS_PER_BIT(CPB), .BAUD_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at sample %0d: got %b expected %b", name, n, act, exp);
    end
  endtask

  // Monitor: sample n follows clock edge n; compare, then predict what edge n+1 does.
  initial begin
    logic   exp_tx, exp_fd, exp_ready, exp_busy, acc;
    int     b, s;
    frame_t f;
    n = 0; armed = 0; last_start = 0; last_end = 0; exp_perr = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      exp_ready = rst_n && !(n < last_start);
      if (armed) begin
        while (q.size() > 0 && (q[0].s + FRAME) <= n) void'(q.pop_front());
        exp_tx = 1'b1;
        exp_fd = 1'b0;
        if (q.size() > 0 && q[0].s <= n) begin
          b      = (n - q[0].s) / CPB;
          exp_tx = q[0].bits[b];
          exp_fd = (n == q[0].s + FRAME - 1);
        end
        exp_busy = (n < last_end);
        check_output("tx_out", tx_out, exp_tx);
        check_output("frame_done", frame_done, exp_fd);
        check_output("busy", busy, exp_busy);
        check_output("din_ready", din_ready, exp_ready);
        check_output("parity_err", parity_err, exp_perr);
      end
      if (!rst_n) begin
        armed      = 1;
        q.delete();
        last_start = 0;
        last_end   = 0;
        exp_perr   = 1'b0;
      end else if (armed) begin
        acc      = din_valid && exp_ready;
        exp_perr = acc && (din[0] != ^din[8:1]);
        if (acc) begin
          s      = (n + 2 > last_end) ? n + 2 : last_end;
          f.s    = s;
          f.bits = {1'b1, din[0], din[8:1], 1'b0};
          q.push_back(f);
          last_start = s;
          last_end   = s + FRAME;
        end
      end
    end
  end

  // Offers one word and holds it until the handshake completes.
  task automatic apply_stimulus(input logic [8:0] word);
    bit done;
    done      = 0;
    din_valid = 1'b1;
    din       = word;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (din_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout word %h: got no handshake expected handshake", word);
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int k = 0; k < 2000 && !idle; k++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got busy expected idle");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] data;
    logic       par;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] single good word");
    apply_stimulus(9'h14A);
    wait_idle();

    $display("[TB] bad parity word");
    apply_stimulus(9'h14B);
    wait_idle();

    $display("[TB] back-to-back words");
    apply_stimulus(9'h14A);
    apply_stimulus(9'h000);
    wait_idle();

    $display("[TB] backpressure with three words");
    apply_stimulus(9'h0F1);
    apply_stimulus(9'h133);
    apply_stimulus(9'h1C5);
    wait_idle();

    $display("[TB] reset mid-frame with a buffered word");
    apply_stimulus(9'h14A);
    repeat (6 * CPB) @(posedge clk);
    #1;
    apply_stimulus(9'h0AB);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5 * CPB) @(posedge clk);
    #1;
    apply_stimulus(9'h1FE);
    wait_idle();

    $display("[TB] randomized words");
    for (int i = 0; i < 25; i++) begin
      data = 8'($urandom_range(0, 255));
      par  = ^data;
      if ($urandom_range(0, 3) == 0) par = ~par;
      apply_stimulus({data, par});
      din = 9'($urandom);
      repeat ($urandom_range(0, 60)) @(posedge clk);
      #1;
    end
    wait_idle();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
